// File: rtl/guess_input_cond.sv
// Button conditioning for the guessing-game FSM: 2-flop synchroniser, per-bit
// debounce FSM with rise pulses, and a free-running pacing tick.
module guess_input_cond #(
    parameter int unsigned N   = 21,
    parameter int unsigned DB  = 16,
    parameter int unsigned DBW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] B,
    output logic [3:0] btn_rise,
    output logic       en
);

    typedef enum logic [1:0] {Idle0, Chk1, Idle1, Chk0} db_state_e;

    localparam logic [DBW-1:0] CntLast = DBW'(DB - 1);

    logic [3:0]   s1_q;
    logic [3:0]   s2_q;
    logic [N-1:0] tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        db_state_e      state_q;
        logic [DBW-1:0] cnt_q;
        logic           b_q;
        logic           rise_q;

        // B and btn_rise are updated on the same edge, so a rise pulse lines up with
        // the first cycle the new level is visible.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= Idle0;
                cnt_q   <= '0;
                b_q     <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                unique case (state_q)
                    Idle0: begin
                        if (s2_q[i]) begin
                            state_q <= Chk1;
                            cnt_q   <= DBW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    Chk1: begin
                        if (!s2_q[i]) begin
                            state_q <= Idle0;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= Idle1;
                            cnt_q   <= '0;
                            b_q     <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    Idle1: begin
                        if (!s2_q[i]) begin
                            state_q <= Chk0;
                            cnt_q   <= DBW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    Chk0: begin
                        if (s2_q[i]) begin
                            state_q <= Idle1;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= Idle0;
                            cnt_q   <= '0;
                            b_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign B[i]        = b_q;
        assign btn_rise[i] = rise_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            en     <= 1'b0;
        end else begin
            tick_q <= tick_q + 1'b1;
            en     <= (tick_q == '1);
        end
    end

endmodule

// File: tb/tb_guess_input_cond.sv
// Self-checking bench for guess_input_cond with a cycle-level behavioural model
// (raw history -> synced level -> run-length debounce; tick from edge count).
module tb_guess_input_cond;

    localparam int N   = 4;
    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam int PER = 1 << N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] B;
    logic [3:0] btn_rise;
    logic       en;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] s1m, s2m, bm, rm;
    int         run [4];
    int         cyc;

    guess_input_cond #(.N(N), .DB(DB), .DBW(DBW)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .B        (B),
        .btn_rise (btn_rise),
        .en       (en)
    );

    always #5 clk = ~clk;

    function automatic logic em();
        return (cyc > 0) && (cyc % PER == 0);
    endfunction

    // Advance one edge; model a level as accepted after DB consecutive disagreeing
    // synced samples.
    task automatic step();
        @(posedge clk);
        rm = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (s2m[i] != bm[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    bm[i]  = ~bm[i];
                    run[i] = 0;
                    if (bm[i]) rm[i] = 1'b1;
                end
            end else begin
                run[i] = 0;
            end
        end
        s2m = s1m;
        s1m = btn_raw;
        cyc++;
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] raw);
        btn_raw = raw;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({B, btn_rise, en} !== 9'h0) begin
            bad++;
            $display("FAIL reset_now: got B=%h rise=%h en=%b want all zero", B, btn_rise, en);
        end
        s1m = 0; s2m = 0; bm = 0; rm = 0; cyc = 0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        @(posedge clk);
        @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(4'h0);
        btn_raw = 4'hF;
        repeat (9) step();
        apply_reset(4'hF);
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (k < 6 && (B !== 4'h0 || btn_rise !== 4'h0)) begin
                bad++;
                $display("FAIL reset_early e%0d: got B=%h rise=%h want 0 0", k, B, btn_rise);
            end else if (k == 6 && (B !== 4'hF || btn_rise !== 4'hF)) begin
                bad++;
                $display("FAIL reset_rise e%0d: got B=%h rise=%h want F F", k, B, btn_rise);
            end else if (k > 6 && (B !== 4'hF || btn_rise !== 4'h0)) begin
                bad++;
                $display("FAIL reset_hold e%0d: got B=%h rise=%h want F 0", k, B, btn_rise);
            end
        end
    endtask

    task automatic test_tick();
        int pulses = 0;
        apply_reset(4'h0);
        for (int k = 1; k <= 64; k++) begin
            step();
            if (en === 1'b1) pulses++;
            total++;
            if (en !== ((k % 16) == 0)) begin
                bad++;
                $display("FAIL tick c%0d: got en=%b want %b", k, en, (k % 16) == 0);
            end
        end
        total++;
        if (pulses != 4) begin
            bad++;
            $display("FAIL tick_count: got %0d want 4", pulses);
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        int edge_at = -1;
        apply_reset(4'h0);
        for (int k = 0; k < 4; k++) begin
            btn_raw[2] = ~k[0];
            step();
            if (btn_rise[2]) rises++;
            total++;
            if (B !== 4'h0) begin
                bad++;
                $display("FAIL bounce_early k%0d: got B=%h want 0", k, B);
            end
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (btn_rise[2]) rises++;
            if (B[2] === 1'b1 && edge_at < 0) edge_at = k;
            total++;
            if ({B, btn_rise} !== {bm, rm}) begin
                bad++;
                $display("FAIL bounce_model k%0d: got B=%h rise=%h want B=%h rise=%h",
                         k, B, btn_rise, bm, rm);
            end
        end
        total++;
        if (edge_at != 6 || rises != 1) begin
            bad++;
            $display("FAIL bounce_lat: got edges=%0d rises=%0d want 6 1", edge_at, rises);
        end
    endtask

    task automatic test_glitch();
        apply_reset(4'h0);
        for (int k = 0; k < 14; k++) begin
            btn_raw[0] = (k < 3);
            step();
            total++;
            if (B !== 4'h0 || btn_rise !== 4'h0) begin
                bad++;
                $display("FAIL glitch k%0d: got B=%h rise=%h want 0 0", k, B, btn_rise);
            end
        end
    endtask

    task automatic test_release();
        int guard = 0;
        int fall_at = -1;
        apply_reset(4'h0);
        btn_raw[1] = 1'b1;
        while (B[1] !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (B[1] !== 1'b1) begin
            bad++;
            $display("FAIL release_press: got B=%h want bit1 set within 20", B);
        end
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (B[1] === 1'b0 && fall_at < 0) fall_at = k;
            total++;
            if (btn_rise !== 4'h0) begin
                bad++;
                $display("FAIL release_rise k%0d: got rise=%h want 0", k, btn_rise);
            end
        end
        total++;
        if (fall_at != 6) begin
            bad++;
            $display("FAIL release_lat: got %0d want 6", fall_at);
        end
    endtask

    task automatic test_overlap();
        int last_en = -1;
        apply_reset(4'h0);
        while ((cyc + 1) % PER != 0) step();
        btn_raw = 4'h3;
        for (int k = 0; k <= 40; k++) begin
            step();
            if (en === 1'b1) begin
                total++;
                if (last_en >= 0 && k - last_en != PER) begin
                    bad++;
                    $display("FAIL overlap_period: got %0d want %0d", k - last_en, PER);
                end
                last_en = k;
            end
            if (k == 0 || k == 5) begin
                total++;
                if (en !== (k == 0) || B !== (k == 5 ? 4'h3 : 4'h0) ||
                    btn_rise !== (k == 5 ? 4'h3 : 4'h0)) begin
                    bad++;
                    $display("FAIL overlap k%0d: got en=%b B=%h rise=%h", k, en, B, btn_rise);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        apply_reset(4'h0);
        for (int seg = 0; seg < 60; seg++) begin
            btn_raw = 4'($urandom);
            hold = $urandom_range(1, 9);
            for (int k = 0; k < hold; k++) begin
                step();
                total++;
                if ({B, btn_rise, en} !== {bm, rm, em()}) begin
                    bad++;
                    $display("FAIL random c%0d: got B=%h rise=%h en=%b want B=%h rise=%h en=%b",
                             cyc, B, btn_rise, en, bm, rm, em());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_bounce();
        test_glitch();
        test_release();
        test_overlap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
